tt_um_probe_capture: RTL
========================

Name: tt_um_probe_capture

Overview:
- TinyTapeout user tile: a trigger-and-capture logic analyser, the parametrised successor to our single-purpose debug tile.
- Samples up to 8 channels from uio_in into a circular buffer and freezes the buffer on a selectable trigger, keeping PRETRIG samples from before the trigger.
- Host reads the buffer back one sample at a time on uo_out, stepped by pin strobes on ui_in.
- Drops into the standard tt_um_* harness unchanged.

Parameters:
- DEPTH, 16, buffer entries; one of 4, 8, 16.
- WIDTH, 8, captured channels uio_in[WIDTH-1:0]; 1..8.
- PRETRIG, 4, samples kept before the trigger sample; 0..DEPTH-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile enable; low freezes all state except synchroniser flops
- ui_in  in  8  [0] arm, [1] read_next, [3:2] trig mode, [6:4] trig channel, [7] abort
- uio_in  in  8  probed signals
- uo_out  out  8  status word, or read data in READOUT
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all uio are inputs)

Behaviour:
- Reset values: state IDLE, all pointers and counters 0, prev sample 0, uo_out 8'h00.
- Control synchronisation: ui_in[0], ui_in[1] and ui_in[7] each pass through a 2-flop synchroniser plus a delay flop.
  - rise = s2 & ~s3.
  - An action takes effect at the 3rd rising edge, counting the edge that first samples the pin high.
- Mode (ui_in[3:2]) and channel (ui_in[6:4]) are used unsynchronised and must be static while armed.
- Abort: synced level; forces IDLE from any state. Highest priority.
- prev: when ena=1, prev <= uio_in[WIDTH-1:0] every cycle.
- Trigger, evaluated on the sample cur written this cycle, for channel ch:
  - 00 immediate: always true.
  - 01 rising: cur[ch] & ~prev[ch].
  - 10 falling: ~cur[ch] & prev[ch].
  - 11 level: cur[ch].
  - ch >= WIDTH: modes 01/10/11 never fire.
- fill: count of samples written before the current one, saturating at DEPTH.
- IDLE (2'b00):
  - No writes.
  - On arm rise: wr_ptr=0, fill=0, go to ARMED.
- ARMED (2'b01):
  - Each cycle: mem[wr_ptr] <= cur, wr_ptr++ mod DEPTH, fill++ (saturating).
  - Trigger with fill < PRETRIG is ignored.
  - Trigger with fill >= PRETRIG: trig_ptr = wr_ptr and post_cnt = DEPTH-PRETRIG-1.
    - If post_cnt == 0, go to READOUT; otherwise go to POST.
- POST (2'b10):
  - Keep writing each cycle and decrement post_cnt.
  - Write that makes post_cnt 0: go to READOUT.
  - Exactly DEPTH samples are retained: PRETRIG before, the trigger sample, DEPTH-PRETRIG-1 after.
- READOUT (2'b11):
  - On entry: rd_ptr = (trig_ptr - PRETRIG) mod DEPTH, rd_cnt = 0.
  - uo_out = mem[rd_ptr], zero-extended to 8 bits; combinational from registered rd_ptr.
  - On read_next rise: rd_ptr++ mod DEPTH, rd_cnt++.
  - Read_next rise with rd_cnt == DEPTH-1: go to IDLE.
  - Arm rise is ignored in READOUT.
- Status word outside READOUT: uo_out = {state[1:0], fill>=PRETRIG, 1'b0, wr_ptr zero-extended to 4 bits}.
- ena=0 freezes state, memory, pointers and prev. Edges that occur while ena=0 are lost.
- Arm in ARMED or POST: no effect.

Decomposition:
- Package tt_probe_pkg holds:
  - state enum IDLE/ARMED/POST/READOUT = 0..3;
  - trigger mode codes;
  - ui_in bit-index constants;
  - status field positions.
- Sub-module probe_sync_edge: 2-flop synchroniser plus delay flop, outputs level and rise. Instantiated 3 times.
- Buffer: flop array DEPTH x WIDTH inside the top module.

Test Plan:
- Reset held, arbitrary inputs -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00; status bits [7:6] = 00 after release.
- Immediate mode, DEPTH16/PRETRIG4, uio_in increments every cycle, first armed sample 0x20:
  - trigger sample 0x24;
  - READOUT status observed;
  - 16 read_next pulses read 0x20..0x2F in order.
- Mode 01, ch=2, uio_in=0x00 held then 0x04 after 8 armed cycles -> readout 0x00 x4, then 0x04 x12.
- Mode 01, ch=0, rising edges at armed samples 2 and 10 -> first edge ignored (fill<4); readout entry 4 is the sample-10 edge.
- Abort pulse mid-POST -> uo_out[7:6]=00 by the 3rd edge; re-arm then captures normally.
- After 16 reads -> IDLE; 17th read_next has no effect.
- ena=0 for 5 cycles mid-ARMED -> wr_ptr unchanged and no samples written.

Source files
------------

// File: rtl/tt_probe_pkg.sv
// Shared definitions for the probe-capture tile: FSM state encoding,
// trigger mode codes, ui_in pin assignments, status word layout and the
// trigger-condition helper.
package tt_probe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        POST    = 2'b10,
        READOUT = 2'b11
    } state_t;

    localparam logic [1:0] TRIG_IMM   = 2'b00;
    localparam logic [1:0] TRIG_RISE  = 2'b01;
    localparam logic [1:0] TRIG_FALL  = 2'b10;
    localparam logic [1:0] TRIG_LEVEL = 2'b11;

    localparam int UI_ARM     = 0;
    localparam int UI_READ    = 1;
    localparam int UI_MODE_LO = 2;
    localparam int UI_MODE_HI = 3;
    localparam int UI_CH_LO   = 4;
    localparam int UI_CH_HI   = 6;
    localparam int UI_ABORT   = 7;

    localparam int STAT_STATE_HI = 7;
    localparam int STAT_STATE_LO = 6;
    localparam int STAT_PRE_OK   = 5;
    localparam int STAT_PTR_HI   = 3;
    localparam int STAT_PTR_LO   = 0;

    // ch_ok is low when the selected channel is not captured; only the
    // immediate mode can fire in that case.
    function automatic logic trig_hit(input logic [1:0] mode,
                                      input logic       cur_bit,
                                      input logic       prev_bit,
                                      input logic       ch_ok);
        logic hit;
        hit = 1'b0;
        case (mode)
            TRIG_IMM:   hit = 1'b1;
            TRIG_RISE:  hit = ch_ok & cur_bit & ~prev_bit;
            TRIG_FALL:  hit = ch_ok & ~cur_bit & prev_bit;
            TRIG_LEVEL: hit = ch_ok & cur_bit;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/tt_probe_sync_edge.sv
// Two-flop synchroniser followed by a delay flop for one control pin.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin        : asynchronous input pin
//   level      : synchronised level (second flop)
//   rise       : one-cycle pulse on a synchronised 0->1 transition
// Runs regardless of the tile enable, so edges seen while disabled are
// simply consumed and lost.
module probe_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/tt_um_probe_capture.sv
// Trigger-and-capture logic analyser tile.
// Ports:
//   ui_in   : [0] arm, [1] read_next, [3:2] trigger mode,
//             [6:4] trigger channel, [7] abort
//   uio_in  : probed signals, channels [WIDTH-1:0] captured
//   uo_out  : status word, or the current buffer sample while in READOUT
//   uio_out : tied low
//   uio_oe  : tied low, all uio pins are inputs
//   ena     : tile enable; low freezes everything but the synchronisers
//   clk, rst_n : clock, asynchronous active-low reset
//
// state   | meaning
// IDLE    | nothing written, waiting for arm
// ARMED   | writing circular buffer, looking for a trigger
// POST    | trigger seen, writing the post-trigger samples
// READOUT | buffer frozen, host steps through it with read_next
module tt_um_probe_capture
    import tt_probe_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int PRETRIG = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [FW-1:0] ONE_F     = FW'(1);
    localparam logic [AW-1:0] PRE_A     = AW'(PRETRIG);
    localparam logic [FW-1:0] PRE_F     = FW'(PRETRIG);
    localparam logic [FW-1:0] DEPTH_F   = FW'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRETRIG - 1);
    localparam logic [AW-1:0] LAST_RD   = AW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [FW-1:0]     fill;
    logic [AW-1:0]     trig_ptr;
    logic [AW-1:0]     post_cnt;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_cnt;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic arm_rise;
    logic read_rise;
    logic abort_lvl;
    logic arm_lvl_unused;
    logic read_lvl_unused;
    logic abort_rise_unused;

    probe_sync_edge u_sync_arm (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ui_in[UI_ARM]),
        .level (arm_lvl_unused),
        .rise  (arm_rise)
    );

    probe_sync_edge u_sync_read (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ui_in[UI_READ]),
        .level (read_lvl_unused),
        .rise  (read_rise)
    );

    probe_sync_edge u_sync_abort (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ui_in[UI_ABORT]),
        .level (abort_lvl),
        .rise  (abort_rise_unused)
    );

    logic [WIDTH-1:0] cur;
    logic [7:0]       cur8;
    logic [7:0]       prev8;
    logic [1:0]       mode;
    logic [2:0]       ch;
    logic             ch_ok;
    logic             hit;
    logic             pre_ok;
    logic [FW-1:0]    fill_inc;
    logic             writing;
    logic             unused_uio;

    // Mode and channel are taken straight from the pins; the host keeps
    // them static while armed, so no synchroniser is needed.
    assign cur        = uio_in[WIDTH-1:0];
    assign cur8       = 8'(cur);
    assign prev8      = 8'(prev);
    assign mode       = ui_in[UI_MODE_HI:UI_MODE_LO];
    assign ch         = ui_in[UI_CH_HI:UI_CH_LO];
    assign ch_ok      = int'(ch) < WIDTH;
    assign hit        = trig_hit(mode, cur8[ch], prev8[ch], ch_ok);
    assign pre_ok     = fill >= PRE_F;
    assign fill_inc   = (fill == DEPTH_F) ? fill : fill + ONE_F;
    assign writing    = ena && !abort_lvl && (state == ARMED || state == POST);
    assign unused_uio = ^uio_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            fill     <= '0;
            trig_ptr <= '0;
            post_cnt <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            prev     <= '0;
        end else if (ena) begin
            prev <= cur;
            if (abort_lvl) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm_rise) begin
                            wr_ptr <= '0;
                            fill   <= '0;
                            state  <= ARMED;
                        end
                    end
                    ARMED: begin
                        wr_ptr <= wr_ptr + ONE_A;
                        fill   <= fill_inc;
                        if (hit && pre_ok) begin
                            trig_ptr <= wr_ptr;
                            post_cnt <= POST_INIT;
                            if (POST_INIT == '0) begin
                                // trigger sample is the last one: freeze now
                                rd_ptr <= wr_ptr - PRE_A;
                                rd_cnt <= '0;
                                state  <= READOUT;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        wr_ptr   <= wr_ptr + ONE_A;
                        fill     <= fill_inc;
                        post_cnt <= post_cnt - ONE_A;
                        if (post_cnt == ONE_A) begin
                            rd_ptr <= trig_ptr - PRE_A;
                            rd_cnt <= '0;
                            state  <= READOUT;
                        end
                    end
                    READOUT: begin
                        if (read_rise) begin
                            rd_ptr <= rd_ptr + ONE_A;
                            rd_cnt <= rd_cnt + ONE_A;
                            if (rd_cnt == LAST_RD) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (writing) begin
            mem[wr_ptr] <= cur;
        end
    end

    always_comb begin
        uo_out = '0;
        if (state == READOUT) begin
            uo_out = 8'(mem[rd_ptr]);
        end else begin
            uo_out[STAT_STATE_HI:STAT_STATE_LO] = state;
            uo_out[STAT_PRE_OK]                 = pre_ok;
            uo_out[STAT_PTR_HI:STAT_PTR_LO]     = 4'(wr_ptr);
        end
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
